// File: rtl/note_sequencer_pkg.sv
// Shared types and defaults for the note sequencer: FSM states and the queued
// command layout.
package seq_pkg;

    localparam int DEF_DEPTH     = 8;
    localparam int DEF_RAMP_STEP = 4;
    localparam int DEF_DUR_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        HOLD,
        RELEASE
    } seq_state_t;

    typedef struct packed {
        logic [15:0]          tune;
        logic [7:0]           vol;
        logic [DEF_DUR_W-1:0] dur;
    } note_cmd_t;

endpackage

// File: rtl/note_sequencer_if.sv
// MCU-side note command bus: valid/ready handshake carrying tune, volume and
// duration of one note.
interface note_sequencer_if #(
    parameter int DUR_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [15:0]      cmd_tune;
    logic [7:0]       cmd_vol;
    logic [DUR_W-1:0] cmd_dur;

    modport master (
        output cmd_valid, cmd_tune, cmd_vol, cmd_dur,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_tune, cmd_vol, cmd_dur,
        output cmd_ready
    );
endinterface

// File: rtl/note_sequencer_fifo.sv
// Single-clock FIFO of note commands; the head entry is presented
// combinationally so the sequencer can decode it on the pop tick.
module note_fifo
    import seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  note_cmd_t                wdata,
    output note_cmd_t                rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    note_cmd_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_q;
    logic              do_push;
    logic              do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr];

    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: queues MCU note commands and plays them back-to-back with a
// linear attack/release ramp, advancing only on the wave-generator tick.
module note_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int DUR_W     = DEF_DUR_W,
    parameter int RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    note_sequencer_if.slave          cmd,
    input  logic                     flush,
    output logic [15:0]              tune_word,
    output logic [7:0]               volume,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     note_done
);

    seq_state_t        state;
    logic [7:0]        target;
    logic [DUR_W-1:0]  dur_cnt;
    note_cmd_t         wr_entry;
    note_cmd_t         head;
    logic [DUR_W-1:0]  head_dur;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [7:0]        vol_up;
    logic [7:0]        vol_dn;

    // Ramp toward the target in 9 bits so 0xFF + step cannot wrap past it.
    function automatic logic [7:0] ramp_up(input logic [7:0] v, input logic [7:0] tgt);
        logic [8:0] s;
        s = {1'b0, v} + 9'(RAMP_STEP);
        return (s >= {1'b0, tgt}) ? tgt : s[7:0];
    endfunction

    function automatic logic [7:0] ramp_down(input logic [7:0] v);
        logic signed [9:0] d;
        d = $signed({2'b00, v}) - $signed(10'(RAMP_STEP));
        return (d <= 10'sd0) ? 8'd0 : d[7:0];
    endfunction

    always_comb begin
        wr_entry      = '0;
        wr_entry.tune = cmd.cmd_tune;
        wr_entry.vol  = cmd.cmd_vol;
        wr_entry.dur  = DEF_DUR_W'(cmd.cmd_dur);
    end

    assign head_dur      = DUR_W'(head.dur);
    assign cmd.cmd_ready = !reset && !full && !flush;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = tick && (state == IDLE) && !empty && !flush;
    assign busy          = (state != IDLE) || !empty;
    assign vol_up        = ramp_up(volume, target);
    assign vol_dn        = ramp_down(volume);

    note_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tune_word <= '0;
            volume    <= '0;
            target    <= '0;
            dur_cnt   <= '0;
            note_done <= 1'b0;
        end else begin
            note_done <= 1'b0;
            // Flush cuts a sounding note straight to its release, tick or not.
            if (flush && (state == ATTACK || state == HOLD)) begin
                state <= RELEASE;
            end else if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (pop) begin
                            if (head_dur == '0) begin
                                note_done <= 1'b1;
                            end else begin
                                tune_word <= head.tune;
                                target    <= head.vol;
                                dur_cnt   <= head_dur;
                                state     <= ATTACK;
                            end
                        end
                    end
                    ATTACK: begin
                        dur_cnt <= dur_cnt - DUR_W'(1);
                        if (dur_cnt == DUR_W'(1)) begin
                            state <= RELEASE;
                        end else begin
                            volume <= vol_up;
                            if (vol_up == target) state <= HOLD;
                        end
                    end
                    HOLD: begin
                        dur_cnt <= dur_cnt - DUR_W'(1);
                        if (dur_cnt == DUR_W'(1)) state <= RELEASE;
                    end
                    RELEASE: begin
                        volume <= vol_dn;
                        if (vol_dn == 8'd0) begin
                            state     <= IDLE;
                            note_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
